// File: rtl/serpent_xts_pkg.sv
// Shared definitions for the Serpent XTS sector controller: FSM encoding,
// the GF(2^128) reduction constant and the default sector geometry.
package serpent_xts_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TWK_REQ,
      S_TWK_WAIT,
      S_BLK_IN,
      S_DAT_REQ,
      S_DAT_WAIT,
      S_BLK_OUT,
      S_DONE
   } xts_state_t;

   localparam logic [127:0] GF_POLY               = 128'h87;
   localparam int           BLOCKS_PER_SECTOR_DEF = 32;

endpackage

// File: rtl/serpent_xts_sector_ctrl_if.sv
// Block streams and shared-cipher request port of the XTS sector controller.
// master = controller side, slave = producer/consumer/cipher-core side.
interface serpent_xts_sector_ctrl_if;

   logic [127:0] i_blk_data;
   logic         i_blk_valid;
   logic         o_blk_ready;

   logic [127:0] o_blk_data;
   logic         o_blk_valid;
   logic         i_blk_ready;

   logic         o_cipher_sel;
   logic         o_cipher_start;
   logic [127:0] o_cipher_data;
   logic         i_cipher_valid;
   logic [127:0] i_cipher_data;

   modport master (
      input  i_blk_data, i_blk_valid, i_blk_ready, i_cipher_valid, i_cipher_data,
      output o_blk_ready, o_blk_data, o_blk_valid, o_cipher_sel, o_cipher_start, o_cipher_data
   );

   modport slave (
      output i_blk_data, i_blk_valid, i_blk_ready, i_cipher_valid, i_cipher_data,
      input  o_blk_ready, o_blk_data, o_blk_valid, o_cipher_sel, o_cipher_start, o_cipher_data
   );

endinterface

// File: rtl/xts_gf_mul_alpha.sv
// Multiply a 128-bit XTS tweak by alpha in GF(2^128); purely combinational.
module xts_gf_mul_alpha
   import serpent_xts_pkg::*;
(
   input  logic [127:0] tweak,
   output logic [127:0] tweak_x2
);

   assign tweak_x2 = {tweak[126:0], 1'b0} ^ (tweak[127] ? GF_POLY : 128'h0);

endmodule

// File: rtl/serpent_xts_sector_ctrl.sv
// XTS sector sequencer around a shared Serpent core: one tweak encryption, then per block P^T -> core -> ^T.
// Latency per block is 2 cycles + core latency + 1 output register; input and output streams stall on valid/ready.
module serpent_xts_sector_ctrl
   import serpent_xts_pkg::*;
#(
   parameter int BLOCKS_PER_SECTOR = BLOCKS_PER_SECTOR_DEF
)
(
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_master_key_valid,
   input  logic                       i_start,
   input  logic [63:0]                i_sector_idx,
   serpent_xts_sector_ctrl_if.master  bus,
   output logic                       o_busy,
   output logic                       o_sector_done,
   output logic [7:0]                 o_blk_cnt
);

   xts_state_t   state, state_nxt;
   logic [63:0]  sector_idx;
   logic [127:0] tweak, tweak_x2, xblk, blk_data;
   logic [7:0]   blk_cnt;
   logic [8:0]   cnt_inc;
   logic         accept_start, in_hs, out_hs, last_blk;
   logic         blk_ready, blk_valid, cipher_sel, cipher_start;
   logic [127:0] cipher_data;

   assign accept_start = i_start && i_master_key_valid && (state == S_IDLE || state == S_DONE);
   assign in_hs        = (state == S_BLK_IN)  && bus.i_blk_valid;
   assign out_hs       = (state == S_BLK_OUT) && bus.i_blk_ready;
   // 9-bit compare so a 256-block sector terminates even though the visible count wraps to 0
   assign cnt_inc      = {1'b0, blk_cnt} + 9'd1;
   assign last_blk     = (cnt_inc == 9'(BLOCKS_PER_SECTOR));

   xts_gf_mul_alpha u_gf_mul_alpha (
      .tweak    (tweak),
      .tweak_x2 (tweak_x2)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      blk_ready     = 1'b0;
      blk_valid     = 1'b0;
      cipher_sel    = 1'b0;
      cipher_start  = 1'b0;
      cipher_data   = 128'h0;
      o_sector_done = 1'b0;
      o_busy        = !(state == S_IDLE || state == S_DONE);
      case (state)
         S_IDLE:     state_nxt = accept_start ? S_TWK_REQ : S_IDLE;
         S_DONE: begin
            o_sector_done = 1'b1;
            state_nxt     = accept_start ? S_TWK_REQ : S_IDLE;
         end
         S_TWK_REQ: begin
            cipher_start = 1'b1;
            cipher_data  = {64'h0, sector_idx};
            state_nxt    = S_TWK_WAIT;
         end
         S_TWK_WAIT: if (bus.i_cipher_valid) state_nxt = S_BLK_IN;
         S_BLK_IN: begin
            blk_ready = 1'b1;
            if (bus.i_blk_valid) state_nxt = S_DAT_REQ;
         end
         S_DAT_REQ: begin
            cipher_start = 1'b1;
            cipher_sel   = 1'b1;
            cipher_data  = xblk;
            state_nxt    = S_DAT_WAIT;
         end
         S_DAT_WAIT: begin
            cipher_sel = 1'b1;
            if (bus.i_cipher_valid) state_nxt = S_BLK_OUT;
         end
         S_BLK_OUT: begin
            blk_valid = 1'b1;
            if (bus.i_blk_ready) state_nxt = last_blk ? S_DONE : S_BLK_IN;
         end
         default:    state_nxt = S_IDLE;
      endcase
      // losing the key schedule abandons the sector without a done pulse
      if (o_busy && !i_master_key_valid) state_nxt = S_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         sector_idx <= 64'h0;
         tweak      <= 128'h0;
         xblk       <= 128'h0;
         blk_data   <= 128'h0;
         blk_cnt    <= 8'h0;
      end else begin
         if (accept_start) begin
            sector_idx <= i_sector_idx;
            blk_cnt    <= 8'h0;
         end
         if (state == S_TWK_WAIT && bus.i_cipher_valid) tweak    <= bus.i_cipher_data;
         if (in_hs)                                     xblk     <= bus.i_blk_data ^ tweak;
         if (state == S_DAT_WAIT && bus.i_cipher_valid) blk_data <= bus.i_cipher_data ^ tweak;
         if (out_hs) begin
            blk_cnt <= cnt_inc[7:0];
            tweak   <= tweak_x2;
         end
      end
   end

   assign bus.o_blk_ready    = blk_ready;
   assign bus.o_blk_valid    = blk_valid;
   assign bus.o_blk_data     = blk_data;
   assign bus.o_cipher_sel   = cipher_sel;
   assign bus.o_cipher_start = cipher_start;
   assign bus.o_cipher_data  = cipher_data;
   assign o_blk_cnt          = blk_cnt;

endmodule

// File: tb/tb_serpent_xts_sector_ctrl.sv
// Bench for the XTS sector controller: stub cipher core, per-sector reference model, scenario tasks.
module tb_serpent_xts_sector_ctrl;
   import serpent_xts_pkg::*;

   localparam int           BPS = 32;
   localparam logic [127:0] A5  = {16{8'hA5}};

   logic        i_clk = 1'b0;
   logic        i_rstn, i_master_key_valid, i_start;
   logic [63:0] i_sector_idx;
   logic        o_busy, o_sector_done;
   logic [7:0]  o_blk_cnt;

   serpent_xts_sector_ctrl_if bus();

   serpent_xts_sector_ctrl #(.BLOCKS_PER_SECTOR(BPS)) dut (
      .i_clk              (i_clk),
      .i_rstn             (i_rstn),
      .i_master_key_valid (i_master_key_valid),
      .i_start            (i_start),
      .i_sector_idx       (i_sector_idx),
      .bus                (bus),
      .o_busy             (o_busy),
      .o_sector_done      (o_sector_done),
      .o_blk_cnt          (o_blk_cnt)
   );

   always #5 i_clk = ~i_clk;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [127:0] twk_key, dat_key;
   bit           dat_rot;
   logic [127:0] p_mem [BPS];
   logic [128:0] req_q [$];
   int           done_cnt = 0;
   int           stub_cnt = 0;
   logic [127:0] stub_res;
   int           last_base, chain_base, chain_dbase;

   // Stub core: key2 is a plain XOR, key1 optionally rotates so the output depends on the tweak
   function automatic logic [127:0] core_fn(input logic sel, input logic [127:0] op);
      if (!sel)    return op ^ twk_key;
      if (dat_rot) return {op[114:0], op[127:115]} ^ dat_key;
      return op ^ dat_key;
   endfunction

   function automatic logic [127:0] gf_double(input logic [127:0] t);
      logic [127:0] r;
      r = t << 1;
      if (t[127]) r = r ^ 128'd135;
      return r;
   endfunction

   always @(negedge i_clk) begin
      bus.i_cipher_valid = 1'b0;
      if (stub_cnt > 0) begin
         stub_cnt--;
         if (stub_cnt == 0) begin
            bus.i_cipher_valid = 1'b1;
            bus.i_cipher_data  = stub_res;
         end
      end
      if (bus.o_cipher_start === 1'b1) begin
         stub_cnt = 3;
         stub_res = core_fn(bus.o_cipher_sel, bus.o_cipher_data);
         req_q.push_back({bus.o_cipher_sel, bus.o_cipher_data});
      end
      if (o_sector_done === 1'b1) done_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required bench completion");
      $fatal(1);
   end

   task automatic fill_p(input bit zero);
      for (int i = 0; i < BPS; i++) p_mem[i] = zero ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic pulse_start(input logic [63:0] idx);
      i_start = 1'b1; i_sector_idx = idx;
      @(negedge i_clk);
      i_start = 1'b0; i_sector_idx = {$urandom, $urandom};
   endtask

   task automatic send_block(input logic [127:0] p, output bit ok);
      int k = 0;
      bus.i_blk_valid = 1'b1; bus.i_blk_data = p;
      while (bus.o_blk_ready !== 1'b1 && k < 200) begin @(negedge i_clk); k++; end
      ok = (k < 200);
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL timeout_blk_ready: no ready after %0d cycles, required within 200", k);
      end else @(negedge i_clk);
      bus.i_blk_valid = 1'b0; bus.i_blk_data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_out(output bit ok);
      int k = 0;
      while (bus.o_blk_valid !== 1'b1 && k < 200) begin @(negedge i_clk); k++; end
      ok = (k < 200);
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL timeout_blk_valid: no valid after %0d cycles, required within 200", k);
      end
   endtask

   // Runs one full sector from the current p_mem and checks every output and cipher request.
   task automatic run_sector(input logic [63:0] idx, input int stall_blk, input bit rand_stall,
                             input int start_blk, input bit pre_started, input bit chain,
                             input logic [63:0] chain_idx);
      logic [127:0] t, p, exp_out;
      logic [128:0] exp_req [$];
      int base, dbase, ns;
      bit ok;
      if (pre_started) begin base = chain_base; dbase = chain_dbase; end
      else begin base = req_q.size(); dbase = done_cnt; pulse_start(idx); end
      last_base = base;
      t = core_fn(1'b0, {64'h0, idx});
      exp_req.push_back({1'b0, 64'h0, idx});
      for (int b = 0; b < BPS; b++) begin
         p = p_mem[b];
         exp_req.push_back({1'b1, p ^ t});
         exp_out = core_fn(1'b1, p ^ t) ^ t;
         send_block(p, ok);
         if (!ok) return;
         if (b == start_blk) begin
            @(negedge i_clk);
            i_start = 1'b1; i_sector_idx = ~idx;
            @(negedge i_clk);
            i_start = 1'b0;
         end
         wait_out(ok);
         if (!ok) return;
         ns = (b == stall_blk) ? 10 : (rand_stall ? int'($urandom_range(0, 3)) : 0);
         for (int s = 0; s < ns; s++) begin
            @(negedge i_clk);
            n_checks++;
            if (bus.o_blk_valid !== 1'b1 || bus.o_blk_data !== exp_out) begin
               n_fail++;
               $display("FAIL stall_hold blk %0d cyc %0d: valid=%b data=%h, required valid=1 data=%h",
                        b, s, bus.o_blk_valid, bus.o_blk_data, exp_out);
            end
         end
         if (ns > 0) begin
            n_checks++;
            if (req_q.size() - base !== b + 2) begin
               n_fail++;
               $display("FAIL stall_no_req blk %0d: %0d requests, required %0d", b, req_q.size() - base, b + 2);
            end
         end
         n_checks++;
         if (bus.o_blk_data !== exp_out) begin
            n_fail++;
            $display("FAIL blk_out %0d: got %h, required %h", b, bus.o_blk_data, exp_out);
         end
         bus.i_blk_ready = 1'b1;
         @(negedge i_clk);
         bus.i_blk_ready = 1'b0;
         n_checks++;
         if (o_blk_cnt !== 8'(b + 1)) begin
            n_fail++;
            $display("FAIL blk_cnt after blk %0d: got %0d, required %0d", b, o_blk_cnt, b + 1);
         end
         t = gf_double(t);
      end
      n_checks++;
      if (o_sector_done !== 1'b1 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: done=%b busy=%b, required done=1 busy=0", o_sector_done, o_busy);
      end
      n_checks++;
      if (req_q.size() - base !== exp_req.size()) begin
         n_fail++;
         $display("FAIL req_count: %0d requests, required %0d", req_q.size() - base, exp_req.size());
      end else begin
         for (int i = 0; i < exp_req.size(); i++) begin
            n_checks++;
            if (req_q[base + i] !== exp_req[i]) begin
               n_fail++;
               $display("FAIL cipher_req %0d: got %h, required %h", i, req_q[base + i], exp_req[i]);
            end
         end
      end
      if (chain) begin
         chain_base = req_q.size();
         pulse_start(chain_idx);
         chain_dbase = done_cnt;
      end else begin
         @(negedge i_clk);
         n_checks++;
         if (o_sector_done !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", o_sector_done, o_busy);
         end
         @(negedge i_clk);
         n_checks++;
         if (done_cnt - dbase !== 1) begin
            n_fail++;
            $display("FAIL done_count: %0d pulses, required 1", done_cnt - dbase);
         end
      end
   endtask

   task automatic test_reset();
      i_rstn = 1'b0;
      repeat (3) @(negedge i_clk);
      n_checks++;
      if ({o_busy, o_sector_done, o_blk_cnt, bus.o_blk_ready, bus.o_blk_valid,
           bus.o_cipher_start, bus.o_cipher_sel} !== 14'h0) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy=%b done=%b cnt=%0d rdy=%b vld=%b cst=%b sel=%b, required all 0",
                  o_busy, o_sector_done, o_blk_cnt, bus.o_blk_ready, bus.o_blk_valid, bus.o_cipher_start, bus.o_cipher_sel);
      end
      n_checks++;
      if (bus.o_blk_data !== 128'h0 || bus.o_cipher_data !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_data: blk=%h cipher=%h, required 0", bus.o_blk_data, bus.o_cipher_data);
      end
      i_rstn = 1'b1;
      repeat (2) @(negedge i_clk);
      n_checks++;
      if (o_busy !== 1'b0 || bus.o_cipher_start !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b cst=%b, required 0 0", o_busy, bus.o_cipher_start);
      end
   endtask

   task automatic test_basic_sector();
      twk_key = A5; dat_key = A5; dat_rot = 1'b0;
      fill_p(1'b1);
      run_sector(64'h0, -1, 1'b0, -1, 1'b0, 1'b0, 64'h0);
      n_checks++;
      if (req_q[last_base] !== {1'b0, 128'h0}) begin
         n_fail++;
         $display("FAIL basic_twk_req: got %h, required sel 0 operand 0", req_q[last_base]);
      end
      n_checks++;
      if (req_q[last_base + 2] !== {1'b1, 128'h4B4B4B4B4B4B4B4B4B4B4B4B4B4B4BCD}) begin
         n_fail++;
         $display("FAIL basic_second_tweak: got %h, required 1_4B..4BCD", req_q[last_base + 2]);
      end
      n_checks++;
      if (bus.o_blk_data !== A5 || o_blk_cnt !== 8'd32) begin
         n_fail++;
         $display("FAIL basic_final: data=%h cnt=%0d, required %h 32", bus.o_blk_data, o_blk_cnt, A5);
      end
   endtask

   task automatic test_gf_boundary();
      dat_key = A5; dat_rot = 1'b0;
      fill_p(1'b1);
      twk_key = {1'b1, 127'h0};
      run_sector(64'h0, -1, 1'b0, -1, 1'b0, 1'b0, 64'h0);
      n_checks++;
      if (req_q[last_base + 2] !== {1'b1, 128'h87}) begin
         n_fail++;
         $display("FAIL gf_msb_wrap: got %h, required 1_00..87", req_q[last_base + 2]);
      end
      twk_key = 128'h1;
      run_sector(64'h0, -1, 1'b0, -1, 1'b0, 1'b0, 64'h0);
      n_checks++;
      if (req_q[last_base + 2] !== {1'b1, 128'h2}) begin
         n_fail++;
         $display("FAIL gf_shift: got %h, required 1_00..02", req_q[last_base + 2]);
      end
      twk_key = A5;
   endtask

   task automatic test_stall();
      fill_p(1'b0);
      run_sector({$urandom, $urandom}, 3, 1'b0, -1, 1'b0, 1'b0, 64'h0);
   endtask

   task automatic test_start_ignored();
      fill_p(1'b0);
      dat_rot = 1'b1;
      run_sector({$urandom, $urandom}, -1, 1'b0, 1, 1'b0, 1'b0, 64'h0);
   endtask

   task automatic test_abort();
      int dbase;
      bit ok;
      dbase = done_cnt;
      pulse_start({$urandom, $urandom});
      send_block({$urandom, $urandom, $urandom, $urandom}, ok);
      @(negedge i_clk);
      i_master_key_valid = 1'b0;
      @(negedge i_clk);
      n_checks++;
      if (o_busy !== 1'b0 || bus.o_blk_valid !== 1'b0 || bus.o_blk_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: busy=%b vld=%b rdy=%b, required 0 0 0", o_busy, bus.o_blk_valid, bus.o_blk_ready);
      end
      repeat (5) @(negedge i_clk);
      n_checks++;
      if (o_busy !== 1'b0 || bus.o_blk_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_stale_result: busy=%b vld=%b, required 0 0", o_busy, bus.o_blk_valid);
      end
      pulse_start(64'h5);
      n_checks++;
      if (o_busy !== 1'b0 || bus.o_cipher_start !== 1'b0) begin
         n_fail++;
         $display("FAIL start_without_key: busy=%b cst=%b, required 0 0", o_busy, bus.o_cipher_start);
      end
      n_checks++;
      if (done_cnt - dbase !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done: %0d pulses, required 0", done_cnt - dbase);
      end
      i_master_key_valid = 1'b1;
      repeat (2) @(negedge i_clk);
   endtask

   task automatic test_reset_mid_sector();
      bit ok;
      dat_rot = 1'b0;
      pulse_start({$urandom, $urandom});
      send_block({$urandom, $urandom, $urandom, $urandom} | 128'h1, ok);
      wait_out(ok);
      i_rstn = 1'b0;
      #1;
      n_checks++;
      if ({o_busy, o_sector_done, o_blk_cnt, bus.o_blk_ready, bus.o_blk_valid,
           bus.o_cipher_start, bus.o_cipher_sel} !== 14'h0 || bus.o_blk_data !== 128'h0
          || bus.o_cipher_data !== 128'h0) begin
         n_fail++;
         $display("FAIL rst_mid_blk_out: busy=%b vld=%b cnt=%0d data=%h, required all 0",
                  o_busy, bus.o_blk_valid, o_blk_cnt, bus.o_blk_data);
      end
      @(negedge i_clk);
      i_rstn = 1'b1;
      pulse_start({$urandom, $urandom});
      send_block({$urandom, $urandom, $urandom, $urandom}, ok);
      @(negedge i_clk);
      i_rstn = 1'b0;
      @(negedge i_clk);
      i_rstn = 1'b1;
      repeat (4) @(negedge i_clk);
      n_checks++;
      if (o_busy !== 1'b0 || bus.o_blk_valid !== 1'b0 || bus.o_blk_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_inflight_ignored: busy=%b vld=%b rdy=%b, required 0 0 0",
                  o_busy, bus.o_blk_valid, bus.o_blk_ready);
      end
   endtask

   task automatic test_random_sector();
      dat_rot = 1'b1;
      twk_key = {$urandom, $urandom, $urandom, $urandom};
      dat_key = {$urandom, $urandom, $urandom, $urandom};
      fill_p(1'b0);
      run_sector({$urandom, $urandom}, -1, 1'b1, -1, 1'b0, 1'b0, 64'h0);
   endtask

   task automatic test_back_to_back();
      logic [63:0] idx_b;
      idx_b = {$urandom, $urandom};
      fill_p(1'b0);
      run_sector({$urandom, $urandom}, -1, 1'b0, -1, 1'b0, 1'b1, idx_b);
      fill_p(1'b0);
      run_sector(idx_b, -1, 1'b1, -1, 1'b1, 1'b0, 64'h0);
   endtask

   initial begin
      i_rstn = 1'b0; i_master_key_valid = 1'b1; i_start = 1'b0; i_sector_idx = 64'h0;
      bus.i_blk_valid = 1'b0; bus.i_blk_data = 128'h0; bus.i_blk_ready = 1'b0;
      twk_key = A5; dat_key = A5; dat_rot = 1'b0;
      test_reset();
      test_basic_sector();
      test_gf_boundary();
      test_stall();
      test_start_ignored();
      test_abort();
      test_reset_mid_sector();
      test_random_sector();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
